// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_t;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam int unsigned InstrBytes     = 4;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential, PC-relative or register-relative target,
// always word-aligned.
module pc_next
  import core_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic [D_WIDTH-1:0] pc,
  input  logic               PCsrc,
  input  logic               jalr,
  input  logic [D_WIDTH-1:0] ImmExt,
  input  logic [D_WIDTH-1:0] jalr_base,
  output logic [D_WIDTH-1:0] pc_nxt
);

  logic [D_WIDTH-1:0] target;

  always_comb begin
    target = pc + D_WIDTH'(InstrBytes);
    if (PCsrc) begin
      if (jalr) begin
        target = (jalr_base + ImmExt) & ~{{(D_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        target = pc + ImmExt;
      end
    end
    // Word-addressed memory: misaligned targets are truncated, never trapped.
    pc_nxt = {target[D_WIDTH-1:2], 2'b00};
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request to imem, hold the returned word for decode,
// then advance the PC from the control unit's decision.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned         D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0]  RESET_PC = D_WIDTH'(ResetPcDefault)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [D_WIDTH-1:0] instr,
  output logic [D_WIDTH-1:0] instr_pc,
  output logic [D_WIDTH-1:0] instr_pc_plus4,
  input  logic               PCsrc,
  input  logic               jalr,
  input  logic [D_WIDTH-1:0] ImmExt,
  input  logic [D_WIDTH-1:0] jalr_base
);

  fetch_state_t       state_q, state_d;
  logic [D_WIDTH-1:0] pc_q, pc_d;
  logic [D_WIDTH-1:0] instr_q, instr_d;
  logic [D_WIDTH-1:0] pc_nxt;

  pc_next #(
    .D_WIDTH (D_WIDTH)
  ) u_pc_next (
    .pc        (pc_q),
    .PCsrc     (PCsrc),
    .jalr      (jalr),
    .ImmExt    (ImmExt),
    .jalr_base (jalr_base),
    .pc_nxt    (pc_nxt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StReq: begin
        // Responses seen here belong to a request abandoned by reset; drop them.
        if (imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_ready) begin
          pc_d    = pc_nxt;
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Request is masked while reset is held so no fetch escapes during reset.
  assign imem_req_valid = (state_q == StReq) && !rst;
  assign instr_valid    = (state_q == StHold);
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_pc       = pc_q;
  assign instr_pc_plus4 = pc_q + D_WIDTH'(InstrBytes);

endmodule
